// File: rtl/rf_sequencer_pkg.sv
// rf_sequencer_pkg: shared constants and types for the register-file sequencer.
//   Widths       : DATA_W (register data), ADDR_W (register index), OP_W, ST_W
//   Opcodes      : OP_LDI, OP_ADD, OP_SUB, OP_MOV
//   FSM encoding : ST_IDLE, ST_READ, ST_EXEC, ST_WRITE
//   instr_t      : latched instruction payload
package rf_sequencer_pkg;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned OP_W   = 2;
  localparam int unsigned ST_W   = 2;

  localparam logic [OP_W-1:0] OP_LDI = 2'b00;
  localparam logic [OP_W-1:0] OP_ADD = 2'b01;
  localparam logic [OP_W-1:0] OP_SUB = 2'b10;
  localparam logic [OP_W-1:0] OP_MOV = 2'b11;

  localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] ST_READ  = 2'd1;
  localparam logic [ST_W-1:0] ST_EXEC  = 2'd2;
  localparam logic [ST_W-1:0] ST_WRITE = 2'd3;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] rd;
    logic [ADDR_W-1:0] rp;
    logic [ADDR_W-1:0] rq;
    logic [DATA_W-1:0] imm;
  } instr_t;

endpackage

// File: rtl/rf_seq_alu.sv
// rf_seq_alu: combinational 4-bit ALU for the register-file sequencer.
//   op     : opcode (ADD, SUB, MOV; LDI yields 0, the immediate bypasses the ALU)
//   p, q   : source operands
//   result : (p+q) mod 16, (p-q) mod 16 or p
//   carry  : carry out of bit 3 for ADD, borrow (p<q) for SUB, 0 otherwise
module rf_seq_alu
  import rf_sequencer_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] p,
  input  logic [DATA_W-1:0] q,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  localparam int unsigned SUM_W = DATA_W + 1;

  logic [SUM_W-1:0] sum;

  always_comb begin
    sum    = '0;
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        sum    = SUM_W'(p) + SUM_W'(q);
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      OP_SUB: begin
        result = p - q;
        carry  = (p < q);
      end
      OP_MOV:  result = p;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/rf_sequencer.sv
// rf_sequencer: four-state sequencer driving an external register file.
//   Clock, Reset             : rising-edge clock, synchronous active-high reset
//   INSTR_VALID/INSTR_READY  : instruction handshake (accepted only in IDLE)
//   INSTR_OP/RD/RP/RQ/IMM    : instruction fields
//   RP, RQ / DATAP, DATAQ    : register-file read addresses / combinational read data
//   WA, LD_DATA, WR          : register-file write port
//   BUSY, DONE               : instruction in flight / one-cycle completion pulse
//   FLAG_Z, FLAG_C           : zero / carry-borrow status, only when RF_SEQ_FLAGS_EN is defined
module rf_sequencer
  import rf_sequencer_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset,
  input  logic              INSTR_VALID,
  output logic              INSTR_READY,
  input  logic [OP_W-1:0]   INSTR_OP,
  input  logic [ADDR_W-1:0] INSTR_RD,
  input  logic [ADDR_W-1:0] INSTR_RP,
  input  logic [ADDR_W-1:0] INSTR_RQ,
  input  logic [DATA_W-1:0] INSTR_IMM,
  output logic [ADDR_W-1:0] RP,
  output logic [ADDR_W-1:0] RQ,
  input  logic [DATA_W-1:0] DATAP,
  input  logic [DATA_W-1:0] DATAQ,
  output logic [ADDR_W-1:0] WA,
  output logic [DATA_W-1:0] LD_DATA,
  output logic              WR,
  output logic              BUSY,
  output logic              DONE
`ifdef RF_SEQ_FLAGS_EN
  ,
  output logic              FLAG_Z,
  output logic              FLAG_C
`endif
);

  logic [ST_W-1:0]   state_q;
  logic [ST_W-1:0]   state_d;
  logic              accept_c;
  instr_t            instr_q;
  logic [DATA_W-1:0] p_q;
  logic [DATA_W-1:0] q_q;
  logic [DATA_W-1:0] result_q;
  logic              wr_q;
  logic              done_q;
  logic              busy_q;
  logic              ready_q;
  logic [DATA_W-1:0] alu_result;

  // Ready is masked by Reset so nothing can be accepted while it is held.
  assign INSTR_READY = ready_q & ~Reset;
  assign RP          = instr_q.rp;
  assign RQ          = instr_q.rq;
  assign WA          = instr_q.rd;
  assign LD_DATA     = result_q;
  assign WR          = wr_q;
  assign DONE        = done_q;
  assign BUSY        = busy_q;

  // State register.
  always_ff @(posedge Clock) begin
    if (Reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; LDI skips straight to WRITE.
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (INSTR_VALID && INSTR_READY) begin
          accept_c = 1'b1;
          state_d  = (INSTR_OP == OP_LDI) ? ST_WRITE : ST_READ;
        end
      end
      ST_READ:  state_d = ST_EXEC;
      ST_EXEC:  state_d = ST_WRITE;
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Status outputs registered from the upcoming state.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      wr_q    <= (state_d == ST_WRITE);
      done_q  <= (state_d == ST_WRITE);
      busy_q  <= (state_d != ST_IDLE);
      ready_q <= (state_d == ST_IDLE);
    end
  end

  // Instruction latch, operand capture and result register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      instr_q  <= '0;
      p_q      <= '0;
      q_q      <= '0;
      result_q <= '0;
    end else begin
      if (accept_c) begin
        instr_q <= '{op: INSTR_OP, rd: INSTR_RD, rp: INSTR_RP, rq: INSTR_RQ, imm: INSTR_IMM};
        if (INSTR_OP == OP_LDI) result_q <= INSTR_IMM;
      end
      if (state_q == ST_READ) begin
        p_q <= DATAP;
        q_q <= DATAQ;
      end
      if (state_q == ST_EXEC) result_q <= alu_result;
    end
  end

`ifdef RF_SEQ_FLAGS_EN
  logic alu_carry;
  logic carry_q;

  rf_seq_alu u_alu (
    .op     (instr_q.op),
    .p      (p_q),
    .q      (q_q),
    .result (alu_result),
    .carry  (alu_carry)
  );

  // Carry is held from EXEC and committed together with Z as WRITE ends.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      carry_q <= 1'b0;
      FLAG_Z  <= 1'b0;
      FLAG_C  <= 1'b0;
    end else begin
      if (state_q == ST_EXEC) carry_q <= alu_carry;
      if (state_q == ST_WRITE) begin
        FLAG_Z <= (result_q == '0);
        if (instr_q.op == OP_ADD || instr_q.op == OP_SUB) FLAG_C <= carry_q;
      end
    end
  end
`else
  logic unused_carry;

  rf_seq_alu u_alu (
    .op     (instr_q.op),
    .p      (p_q),
    .q      (q_q),
    .result (alu_result),
    .carry  (unused_carry)
  );
`endif

endmodule
